pool_2x2: RTL
=============

POOL_2X2 -- requirements
Module: pool_2x2

Interface
REQ-001 Parameter WIDTH, -1, active image width in pixels; the instantiating layer sets it and it must be at least 2.
REQ-002 Parameter HEIGHT, -1, active image height in lines; must be at least 2.
REQ-003 Parameter W_WIDTH, -1, frame width including blanking; must be at least WIDTH.
REQ-004 Parameter W_HEIGHT, -1, frame height including blanking; must be at least HEIGHT.
REQ-005 Parameter BITW, -1, signed fixed-point width of one channel (INT_BITW+FRAC_BITW of the upstream layer).
REQ-006 Parameter UNITS, -1, number of channels per pixel.
REQ-007 Port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-008 Port rst, input, 1, synchronous active-high reset.
REQ-009 Port in_enable, input, 1, stream-valid for the current input sample.
REQ-010 Port in_pixels, input, BITW*UNITS, packed channels [0:BITW*UNITS-1]; channel u at [u*BITW +: BITW], two's complement.
REQ-011 Port in_vcnt, input, log2(W_HEIGHT), frame line of the current sample.
REQ-012 Port in_hcnt, input, log2(W_WIDTH), frame column of the current sample.
REQ-013 Port out_valid, output, 1, one-cycle pulse marking a pooled pixel.
REQ-014 Port out_pixels, output, BITW*UNITS, pooled channels, same packing as in_pixels.
REQ-015 Port out_vcnt, output, log2(W_HEIGHT), in_vcnt>>1 of the producing sample.
REQ-016 Port out_hcnt, output, log2(W_WIDTH), in_hcnt>>1 of the producing sample.

Function
REQ-017 A sample is accepted only when in_enable=1, FSM=RUN, in_vcnt<HEIGHT and in_hcnt<WIDTH; all other cycles leave internal state unchanged.
REQ-018 FSM states: WAIT_SOF and RUN.
- Reset enters WAIT_SOF.
- WAIT_SOF to RUN when in_enable=1 with in_vcnt=0 and in_hcnt=0; that sample is accepted.
- RUN remains RUN; there is no other exit except rst.
REQ-019 Even-column accepted sample: per-channel value is stored in the horizontal register hreg.
REQ-020 Odd-column accepted sample: hmax[u] = signed max(hreg[u], in[u]).
REQ-021 Even line, odd column: hmax is written to the line buffer at index in_hcnt>>1; depth is WIDTH/2 (floor), width BITW*UNITS.
REQ-022 Odd line, odd column: result[u] = signed max(linebuf[in_hcnt>>1][u], hmax[u]), emitted as a pooled pixel.
REQ-023 Timing of the pooled output:
- out_valid=1 exactly 2 cycles after the producing sample.
- out_pixels, out_vcnt and out_hcnt are valid in the same cycle as out_valid.
- Fixed latency; no backpressure.
REQ-024 out_pixels, out_vcnt and out_hcnt hold their last value when out_valid=0.
REQ-025 Odd WIDTH: last column is discarded. Odd HEIGHT: last line is discarded. No partial windows are output.
REQ-026 Max is a signed compare; on equal values either operand may be taken because the result is identical. No widening or rounding.
REQ-027 in_enable low mid-line: the pending hreg and line-buffer contents are retained and pooling resumes on the next accepted sample.
REQ-028 A line-buffer read and write to the same index never occur in the same cycle; writes happen only on even lines and reads only on odd lines.
REQ-029 Output rate is at most 1 pooled pixel per 2 input cycles and 1 per 4 accepted samples per frame.

Reset
REQ-030 While rst=1 on a rising edge, the following clear to 0: out_valid, out_pixels, out_vcnt, out_hcnt, hreg, and the 2-stage output pipeline. The FSM goes to WAIT_SOF.
REQ-031 Line-buffer contents are not reset; WAIT_SOF guarantees they are rewritten before being read.
REQ-032 rst asserted mid-frame: in-flight pooled pixels are dropped, and no out_valid occurs until 2 cycles after the odd/odd sample of the next frame.

Verification
REQ-033 Configuration: WIDTH=4, HEIGHT=4, W_WIDTH=6, W_HEIGHT=5, BITW=8, UNITS=2, in_enable=1 continuously. Channel 0 = v*4+h, channel 1 = -(v*4+h). The bench SHALL check:
- Exactly 4 out_valid pulses per frame.
- Channel 0 values 5, 7, 13, 15; channel 1 values -0, -2, -8, -10.
- Each pulse 2 cycles after the (1,1), (1,3), (3,1) and (3,3) samples.
- Coordinates (0,0), (0,1), (1,0), (1,1).
REQ-034 Negative window: channel 0 = -128, -1, -5, -128 in window (0,0) -> out channel 0 = -1.
REQ-035 in_enable=0 for 3 cycles between h=0 and h=1 of line 1 -> same pooled values as REQ-033; out_valid is delayed accordingly.
REQ-036 Odd size: WIDTH=5, HEIGHT=5 -> 4 pulses per frame; column 4 and line 4 are never observed in the output.
REQ-037 Reset mid-frame:
- rst pulsed at v=1, h=2 -> out_valid=0 from the next edge until frame start.
- Samples before the next v=0,h=0 are ignored.
- The next frame produces the REQ-033 results exactly.
REQ-038 Start mid-frame: rst released at v=2 -> no output until the next frame; the first pulse has out_vcnt=0, out_hcnt=0.

Source files
------------

// File: rtl/pool_2x2.sv
// pool_2x2: 2x2 max pooling over a raster-scanned multi-channel stream.
// The block keeps one horizontal pair in hreg, and the pair maxima of
// even lines in a half-width line buffer. On odd lines it combines the
// stored maxima with the current pair maxima. A two-stage pipeline
// registers the pooled pixel and its coordinates.
module pool_2x2 #(
  parameter int WIDTH    = 4,
  parameter int HEIGHT   = 4,
  parameter int W_WIDTH  = 6,
  parameter int W_HEIGHT = 5,
  parameter int BITW     = 8,
  parameter int UNITS    = 2
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic                          in_enable,
  input  logic [BITW*UNITS-1:0]         in_pixels,
  input  logic [$clog2(W_HEIGHT)-1:0]   in_vcnt,
  input  logic [$clog2(W_WIDTH)-1:0]    in_hcnt,
  output logic                          out_valid,
  output logic [BITW*UNITS-1:0]         out_pixels,
  output logic [$clog2(W_HEIGHT)-1:0]   out_vcnt,
  output logic [$clog2(W_WIDTH)-1:0]    out_hcnt
);

  localparam int PW       = BITW * UNITS;
  localparam int VW       = $clog2(W_HEIGHT);
  localparam int HW       = $clog2(W_WIDTH);
  localparam int LB_DEPTH = WIDTH / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // Signed maximum of one channel; ties return either operand (identical).
  function automatic logic [BITW-1:0] smax(input logic [BITW-1:0] a,
                                           input logic [BITW-1:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

  logic             in_active;
  logic             sof;
  logic             accept;
  logic             col_odd;
  logic             line_odd;
  logic             lb_write;
  logic             lb_read;
  logic [LB_AW-1:0] lb_idx;

  logic [PW-1:0]    hreg;
  logic [PW-1:0]    hmax;
  logic [PW-1:0]    linebuf [0:LB_DEPTH-1];

  logic             s1_valid;
  logic [PW-1:0]    s1_hmax;
  logic [PW-1:0]    s1_lb;
  logic [VW-1:0]    s1_vcnt;
  logic [HW-1:0]    s1_hcnt;
  logic [PW-1:0]    vmax;

  // Samples outside the active window (blanking) never touch state.
  assign in_active = (32'(in_vcnt) < 32'(HEIGHT)) && (32'(in_hcnt) < 32'(WIDTH));
  assign sof       = in_enable && (in_vcnt == '0) && (in_hcnt == '0);
  // The start-of-frame sample itself is accepted while still in WAIT_SOF.
  assign accept    = !rst && in_enable && in_active && ((state == RUN) || sof);
  assign col_odd   = in_hcnt[0];
  assign line_odd  = in_vcnt[0];
  assign lb_idx    = LB_AW'(in_hcnt >> 1);
  // Writes only on even lines, reads only on odd lines: never both at once.
  assign lb_write  = accept && !line_odd && col_odd;
  assign lb_read   = accept && line_odd && col_odd;

  // FSM state register.
  always_ff @(posedge clock) begin
    if (rst) begin
      state <= WAIT_SOF;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: wait for the first pixel of a frame, then run forever.
  always_comb begin
    state_next = state;
    case (state)
      WAIT_SOF: begin
        if (sof) begin
          state_next = RUN;
        end else begin
          state_next = WAIT_SOF;
        end
      end
      RUN: begin
        state_next = RUN;
      end
      default: begin
        state_next = WAIT_SOF;
      end
    endcase
  end

  // Hold the even-column sample until its odd-column partner arrives.
  always_ff @(posedge clock) begin
    if (rst) begin
      hreg <= '0;
    end else if (accept && !col_odd) begin
      hreg <= in_pixels;
    end else begin
      hreg <= hreg;
    end
  end

  // Per-channel horizontal max of the held sample and the current sample.
  always_comb begin
    hmax = '0;
    for (int u = 0; u < UNITS; u++) begin
      hmax[u*BITW +: BITW] = smax(hreg[u*BITW +: BITW], in_pixels[u*BITW +: BITW]);
    end
  end

  // Line buffer write of even-line pair maxima; contents are not reset.
  always_ff @(posedge clock) begin
    if (lb_write) begin
      linebuf[lb_idx] <= hmax;
    end
  end

  // Pipeline stage 1: capture pair max, stored line max and coordinates.
  always_ff @(posedge clock) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_hmax  <= '0;
      s1_lb    <= '0;
      s1_vcnt  <= '0;
      s1_hcnt  <= '0;
    end else begin
      s1_valid <= lb_read;
      if (lb_read) begin
        s1_hmax <= hmax;
        s1_lb   <= linebuf[lb_idx];
        s1_vcnt <= in_vcnt >> 1;
        s1_hcnt <= in_hcnt >> 1;
      end
    end
  end

  // Per-channel vertical max completing the 2x2 window.
  always_comb begin
    vmax = '0;
    for (int u = 0; u < UNITS; u++) begin
      vmax[u*BITW +: BITW] = smax(s1_lb[u*BITW +: BITW], s1_hmax[u*BITW +: BITW]);
    end
  end

  // Pipeline stage 2: registered outputs that hold between pulses.
  always_ff @(posedge clock) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_pixels <= '0;
      out_vcnt   <= '0;
      out_hcnt   <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_pixels <= vmax;
        out_vcnt   <= s1_vcnt;
        out_hcnt   <= s1_hcnt;
      end
    end
  end

endmodule
